// File: rtl/rgb565_cam_capture_pkg.sv
// Shared types for the RGB565 camera capture block: FSM states and the
// pixel word stored in the FIFO.
package rgb565_cam_pkg;

  localparam int unsigned PIX_W = 18;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    FRAME   = 2'd2
  } state_e;

  typedef struct packed {
    logic [15:0] tdata;
    logic        tuser;
    logic        tlast;
  } pix_t;

endpackage

// File: rtl/rgb565_cam_capture_if.sv
// AXI4-Stream video channel carrying RGB565 pixels with SOF (tuser) and EOL (tlast).
interface rgb565_axis_if;

  logic [15:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tuser;
  logic        tlast;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);

endinterface

// File: rtl/rgb565_cam_capture_fifo.sv
// Synchronous pixel FIFO; pointers carry one extra wrap bit to tell full from empty.
module rgb565_pix_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [Width-1:0] i_wdata,
  input  logic             i_pop,
  output logic [Width-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_wr;
  logic             w_rd;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_rd    = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign w_wr    = i_push & (~o_full | w_rd);
  assign o_rdata = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_rd) r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/rgb565_cam_capture.sv
// OV7670-style camera bus oversampler: pairs bytes into RGB565 pixels and emits an
// AXI4-Stream video channel through a small FIFO, with sticky error flags.
module rgb565_cam_capture
  import rgb565_cam_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic                cam_pclk,
  input  logic                cam_vsync,
  input  logic                cam_href,
  input  logic [7:0]          cam_data,
  input  logic                capture_en,
  input  logic                err_clear,
  rgb565_axis_if.master       m_axis,
  output logic                ovf_err,
  output logic                odd_err,
  output logic [15:0]         frame_cnt
);

  localparam int unsigned LAST = SYNC_STAGES - 1;

  logic [SYNC_STAGES-1:0]      r_pclk_s, r_vsync_s, r_href_s;
  logic [SYNC_STAGES-1:0][7:0] r_data_s;
  logic                        r_pclk_q, r_vsync_q, r_href_q;
  logic [7:0]                  r_data_q;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_pclk_s  <= '0;
      r_vsync_s <= '0;
      r_href_s  <= '0;
      r_data_s  <= '0;
      r_pclk_q  <= 1'b0;
      r_vsync_q <= 1'b0;
      r_href_q  <= 1'b0;
      r_data_q  <= '0;
    end else begin
      r_pclk_s[0]  <= cam_pclk;
      r_vsync_s[0] <= cam_vsync;
      r_href_s[0]  <= cam_href;
      r_data_s[0]  <= cam_data;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_pclk_s[i]  <= r_pclk_s[i-1];
        r_vsync_s[i] <= r_vsync_s[i-1];
        r_href_s[i]  <= r_href_s[i-1];
        r_data_s[i]  <= r_data_s[i-1];
      end
      r_pclk_q  <= r_pclk_s[LAST];
      r_vsync_q <= r_vsync_s[LAST];
      r_href_q  <= r_href_s[LAST];
      r_data_q  <= r_data_s[LAST];
    end
  end

  logic w_pclk_rise, w_href, w_href_rise, w_href_fall, w_vsync_rise, w_vsync_fall;

  assign w_pclk_rise  = r_pclk_s[LAST] & ~r_pclk_q;
  assign w_href       = r_href_s[LAST];
  assign w_href_rise  = w_href & ~r_href_q;
  assign w_href_fall  = ~w_href & r_href_q;
  assign w_vsync_rise = r_vsync_s[LAST] & ~r_vsync_q;
  assign w_vsync_fall = ~r_vsync_s[LAST] & r_vsync_q;

  state_e r_state, w_state_next;
  logic   w_frame_start, w_frame_end;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_frame_start = 1'b0;
    w_frame_end   = 1'b0;
    unique case (r_state)
      IDLE:    if (capture_en) w_state_next = WAIT_VS;
      WAIT_VS: if (w_vsync_fall) begin
        w_frame_start = 1'b1;
        w_state_next  = FRAME;
      end
      FRAME:   if (w_vsync_rise) begin
        w_frame_end  = 1'b1;
        w_state_next = capture_en ? WAIT_VS : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  logic        r_phase, r_hold_vld, r_sof, r_ovf, r_odd;
  logic [7:0]  r_hi;
  logic [15:0] r_frame_cnt;
  pix_t        r_hold;

  logic w_in_frame, w_line_end, w_byte, w_phase, w_pix_done;
  logic w_push, w_pop, w_full, w_empty, w_ovf_set;
  pix_t w_new_pix, w_push_pix, w_head;

  always_comb begin
    w_in_frame = (r_state == FRAME);
    // vsync rise takes priority over a coincident line end; either one flushes the holdback.
    w_line_end = w_in_frame & ~w_vsync_rise & w_href_fall;
    w_byte     = w_in_frame & ~w_vsync_rise & w_pclk_rise & w_href;
    w_phase    = w_href_rise ? 1'b0 : r_phase;
    w_pix_done = w_byte & w_phase;
    w_push     = r_hold_vld & (w_frame_end | w_line_end | w_pix_done);
    w_push_pix       = r_hold;
    w_push_pix.tlast = ~w_pix_done;
    w_new_pix.tdata  = {r_hi, r_data_q};
    w_new_pix.tuser  = r_sof;
    w_new_pix.tlast  = 1'b0;
    w_pop      = ~w_empty & m_axis.tready;
    w_ovf_set  = w_push & w_full & ~w_pop;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_phase     <= 1'b0;
      r_hi        <= '0;
      r_hold      <= '0;
      r_hold_vld  <= 1'b0;
      r_sof       <= 1'b0;
      r_frame_cnt <= '0;
      r_ovf       <= 1'b0;
      r_odd       <= 1'b0;
    end else begin
      if (w_frame_end || w_line_end) begin
        r_phase    <= 1'b0;
        r_hold_vld <= 1'b0;
      end else if (w_byte) begin
        if (!w_phase) begin
          r_hi    <= r_data_q;
          r_phase <= 1'b1;
        end else begin
          r_hold     <= w_new_pix;
          r_hold_vld <= 1'b1;
          r_sof      <= 1'b0;
          r_phase    <= 1'b0;
        end
      end else if (w_href_rise) begin
        r_phase <= 1'b0;
      end
      if (w_frame_start) r_sof <= 1'b1;
      if (w_frame_end)   r_frame_cnt <= r_frame_cnt + 16'd1;
      // A new error in the clearing cycle keeps the flag set.
      r_ovf <= (r_ovf & ~err_clear) | w_ovf_set;
      r_odd <= (r_odd & ~err_clear) | (w_line_end & w_phase);
    end
  end

  rgb565_pix_fifo #(
    .Depth(FIFO_DEPTH),
    .Width(PIX_W)
  ) u_fifo (
    .clk     (ACLK),
    .rst     (ARESET),
    .i_push  (w_push),
    .i_wdata (w_push_pix),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign m_axis.tvalid = ~w_empty;
  assign m_axis.tdata  = w_head.tdata;
  assign m_axis.tuser  = w_head.tuser;
  assign m_axis.tlast  = w_head.tlast;
  assign ovf_err       = r_ovf;
  assign odd_err       = r_odd;
  assign frame_cnt     = r_frame_cnt;

endmodule

// File: tb/tb_rgb565_cam_capture.sv
// Bench for rgb565_cam_capture: drives a slow camera bus and compares stream beats
// against a frame/line/byte-level reference model.
module tb_rgb565_cam_capture;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        cam_pclk, cam_vsync, cam_href;
  logic [7:0]  cam_data;
  logic        capture_en, err_clear;
  logic        ovf_err, odd_err;
  logic [15:0] frame_cnt;

  rgb565_axis_if axis ();

  rgb565_cam_capture #(
    .FIFO_DEPTH (16),
    .SYNC_STAGES(2)
  ) dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .cam_pclk  (cam_pclk),
    .cam_vsync (cam_vsync),
    .cam_href  (cam_href),
    .cam_data  (cam_data),
    .capture_en(capture_en),
    .err_clear (err_clear),
    .m_axis    (axis),
    .ovf_err   (ovf_err),
    .odd_err   (odd_err),
    .frame_cnt (frame_cnt)
  );

  always #5 ACLK = ~ACLK;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [17:0] exp_q[$];
  logic [17:0] obs_q[$];
  int          exp_frame_cnt = 0;
  logic        armed = 1'b0, in_frame = 1'b0, exp_sof = 1'b0, exp_odd = 1'b0;
  bit          rdy_rand = 1'b0;
  logic        rdy_level = 1'b0;

  // Sole driver of tready: either a fixed level or a coin toss each cycle.
  initial begin
    axis.tready = 1'b0;
    forever begin
      @(posedge ACLK);
      #2;
      axis.tready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_level;
    end
  end

  always @(negedge ACLK) begin
    if (ARESET === 1'b0 && axis.tvalid === 1'b1 && axis.tready === 1'b1)
      obs_q.push_back({axis.tdata, axis.tuser, axis.tlast});
  end

  initial begin
    #1ms;
    $display("FAIL watchdog expired obs=%0d exp=%0d", obs_q.size(), exp_q.size());
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge ACLK);
    #2;
  endtask

  task automatic set_cap(input logic v);
    capture_en = v;
    if (v && !in_frame) armed = 1'b1;
    tick(2);
  endtask

  task automatic cam_byte(input logic [7:0] b);
    cam_data = b;
    tick(4);
    cam_pclk = 1'b1;
    tick(4);
    cam_pclk = 1'b0;
  endtask

  task automatic model_frame_end();
    if (in_frame) begin
      exp_frame_cnt = (exp_frame_cnt + 1) & 16'hFFFF;
      if (!capture_en) armed = 1'b0;
    end
    in_frame = 1'b0;
  endtask

  task automatic frame_start();
    cam_vsync = 1'b0;
    tick(8);
    in_frame = armed;
    exp_sof  = 1'b1;
  endtask

  task automatic frame_end();
    cam_vsync = 1'b1;
    tick(8);
    model_frame_end();
  endtask

  // One camera line; expected pixels are byte pairs, the last of the line marked EOL.
  task automatic send_line(input int nbytes, input bit rnd, input logic [7:0] seed,
                           input bit vsync_end);
    logic [7:0] b[$];
    logic [7:0] v;
    cam_href = 1'b1;
    tick(2);
    for (int i = 0; i < nbytes; i++) begin
      v = rnd ? 8'($urandom) : 8'(seed + 8'(i * 34));
      b.push_back(v);
      cam_byte(v);
    end
    tick(2);
    if (vsync_end) begin
      cam_vsync = 1'b1;
      tick(8);
    end
    cam_href = 1'b0;
    tick(8);
    if (in_frame) begin
      for (int p = 0; p < nbytes / 2; p++) begin
        exp_q.push_back({b[2*p], b[2*p+1], exp_sof, 1'(p == nbytes / 2 - 1)});
        exp_sof = 1'b0;
      end
      if ((nbytes % 2) == 1 && !vsync_end) exp_odd = 1'b1;
    end
    if (vsync_end) model_frame_end();
  endtask

  task automatic wait_beats(input int n, output bit ok);
    int t = 0;
    while (obs_q.size() < n && t < 3000) begin
      tick(1);
      t++;
    end
    ok = (obs_q.size() >= n);
    tick(4);
  endtask

  task automatic pulse_clear();
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    ARESET = 1'b1; cam_pclk = 1'b0; cam_vsync = 1'b1; cam_href = 1'b0; cam_data = '0;
    capture_en = 1'b0; err_clear = 1'b0;
    tick(3);
    n_checks++;
    if ({axis.tvalid, axis.tdata, axis.tuser, axis.tlast} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_stream got %h want 0", {axis.tvalid, axis.tdata, axis.tuser, axis.tlast});
    end
    n_checks++;
    if ({ovf_err, odd_err, frame_cnt} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_status got %h want 0", {ovf_err, odd_err, frame_cnt});
    end
    ARESET = 1'b0;
    tick(4);
    n_checks++;
    if (axis.tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_tvalid got %b want 0", axis.tvalid);
    end
  endtask

  task automatic test_basic();
    bit ok;
    rdy_level = 1'b1;
    set_cap(1'b1);
    tick(4);
    frame_start();
    send_line(8, 1'b0, 8'h12, 1'b0);
    send_line(8, 1'b0, 8'h22, 1'b0);
    frame_end();
    wait_beats(8, ok);
    n_checks++;
    if (!ok || obs_q.size() != 8) begin
      n_fail++;
      $display("FAIL basic_count got %0d want 8", obs_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL basic_beat%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    if (obs_q.size() >= 8) begin
      n_checks++;
      if ({obs_q[0][17:1], obs_q[3][0], obs_q[7][0]} !== {16'h1234, 1'b1, 1'b1, 1'b1}) begin
        n_fail++;
        $display("FAIL basic_first_tdata_tuser_tlast got %h want %h",
                 {obs_q[0][17:1], obs_q[3][0], obs_q[7][0]}, {16'h1234, 3'b111});
      end
    end
    n_checks++;
    if (frame_cnt !== 16'(exp_frame_cnt)) begin
      n_fail++;
      $display("FAIL basic_frame_cnt got %0d want %0d", frame_cnt, exp_frame_cnt);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_overflow();
    bit ok;
    rdy_level = 1'b0;
    tick(2);
    frame_start();
    send_line(34, 1'b1, 8'h00, 1'b0);
    void'(exp_q.pop_back());
    for (int s = 0; s < 3; s++) begin
      n_checks++;
      if ({axis.tvalid, axis.tdata} !== {1'b1, exp_q[0][17:2]}) begin
        n_fail++;
        $display("FAIL stall_hold%0d got %h want %h", s, {axis.tvalid, axis.tdata},
                 {1'b1, exp_q[0][17:2]});
      end
      tick(5);
    end
    n_checks++;
    if (ovf_err !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set got %b want 1", ovf_err);
    end
    rdy_level = 1'b1;
    wait_beats(16, ok);
    frame_end();
    n_checks++;
    if (!ok || obs_q.size() != 16) begin
      n_fail++;
      $display("FAIL ovf_count got %0d want 16", obs_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL ovf_beat%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    pulse_clear();
    n_checks++;
    if ({ovf_err, frame_cnt} !== {1'b0, 16'(exp_frame_cnt)}) begin
      n_fail++;
      $display("FAIL ovf_clear_cnt got %h want %h", {ovf_err, frame_cnt}, {1'b0, 16'(exp_frame_cnt)});
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_odd_line();
    bit ok;
    frame_start();
    send_line(7, 1'b1, 8'h00, 1'b0);
    frame_end();
    wait_beats(3, ok);
    n_checks++;
    if (!ok || obs_q.size() != 3) begin
      n_fail++;
      $display("FAIL odd_count got %0d want 3", obs_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL odd_beat%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (odd_err !== exp_odd) begin
      n_fail++;
      $display("FAIL odd_set got %b want %b", odd_err, exp_odd);
    end
    pulse_clear();
    exp_odd = 1'b0;
    n_checks++;
    if (odd_err !== 1'b0) begin
      n_fail++;
      $display("FAIL odd_clear got %b want 0", odd_err);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_vsync_mid_line();
    bit ok;
    frame_start();
    send_line(6, 1'b1, 8'h00, 1'b1);
    n_checks++;
    if (frame_cnt !== 16'(exp_frame_cnt)) begin
      n_fail++;
      $display("FAIL midvs_frame_cnt got %0d want %0d", frame_cnt, exp_frame_cnt);
    end
    // Back in WAIT_VS: the very next frame must be captured from its start.
    frame_start();
    send_line(4, 1'b1, 8'h00, 1'b0);
    frame_end();
    wait_beats(5, ok);
    n_checks++;
    if (!ok || obs_q.size() != 5) begin
      n_fail++;
      $display("FAIL midvs_count got %0d want 5", obs_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL midvs_beat%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    rdy_level = 1'b0;
    tick(2);
    frame_start();
    send_line(3, 1'b1, 8'h00, 1'b0);
    cam_href = 1'b1;
    tick(2);
    for (int i = 0; i < 10; i++) cam_byte(8'($urandom));
    tick(2);
    n_checks++;
    if ({axis.tvalid, odd_err} !== 2'b11) begin
      n_fail++;
      $display("FAIL rstmid_pre got %b want 11", {axis.tvalid, odd_err});
    end
    ARESET = 1'b1;
    #1;
    n_checks++;
    if ({axis.tvalid, ovf_err, odd_err, frame_cnt} !== 19'd0) begin
      n_fail++;
      $display("FAIL rstmid_async got %h want 0", {axis.tvalid, ovf_err, odd_err, frame_cnt});
    end
    tick(3);
    ARESET = 1'b0;
    obs_q.delete(); exp_q.delete();
    in_frame = 1'b0; exp_frame_cnt = 0; exp_odd = 1'b0; armed = capture_en;
    cam_href = 1'b0;
    tick(8);
    frame_end();
    rdy_level = 1'b1;
    frame_start();
    send_line(8, 1'b1, 8'h00, 1'b0);
    frame_end();
    wait_beats(4, ok);
    n_checks++;
    if (!ok || obs_q.size() != 4) begin
      n_fail++;
      $display("FAIL rstmid_count got %0d want 4", obs_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rstmid_beat%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    if (obs_q.size() > 0) begin
      n_checks++;
      if (obs_q[0][1] !== 1'b1) begin
        n_fail++;
        $display("FAIL rstmid_sof got %b want 1", obs_q[0][1]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_capture_disable();
    bit ok;
    frame_start();
    send_line(4, 1'b1, 8'h00, 1'b0);
    set_cap(1'b0);
    send_line(6, 1'b1, 8'h00, 1'b0);
    frame_end();
    frame_start();
    send_line(8, 1'b1, 8'h00, 1'b0);
    frame_end();
    wait_beats(exp_q.size(), ok);
    tick(40);
    n_checks++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL capoff_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL capoff_beat%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (frame_cnt !== 16'(exp_frame_cnt)) begin
      n_fail++;
      $display("FAIL capoff_frame_cnt got %0d want %0d", frame_cnt, exp_frame_cnt);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    bit ok;
    int nl;
    set_cap(1'b1);
    rdy_rand = 1'b1;
    for (int f = 0; f < 3; f++) begin
      frame_start();
      nl = $urandom_range(1, 3);
      for (int l = 0; l < nl; l++) send_line($urandom_range(2, 20), 1'b1, 8'h00, 1'b0);
      frame_end();
    end
    rdy_rand  = 1'b0;
    rdy_level = 1'b1;
    wait_beats(exp_q.size(), ok);
    n_checks++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rand_beat%0d got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if ({odd_err, ovf_err, frame_cnt} !== {exp_odd, 1'b0, 16'(exp_frame_cnt)}) begin
      n_fail++;
      $display("FAIL rand_status got %h want %h", {odd_err, ovf_err, frame_cnt},
               {exp_odd, 1'b0, 16'(exp_frame_cnt)});
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_odd_line();
    test_vsync_mid_line();
    test_reset_mid_frame();
    test_capture_disable();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
